// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline: scan directions,
// result-writer FSM states and the pixel type.
package canny_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [1:0] IDX_LAST = 2'd2;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FLUSH = 2'd2
  } wr_state_t;

endpackage

// File: rtl/nms_addr_gen.sv
// Maps a window origin, scan direction and slot index to the output pixel
// address and an in-image flag. Purely combinational.
module nms_addr_gen
  import canny_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic [15:0]       win_row,
  input  logic [15:0]       win_col,
  input  logic [1:0]        shift_dir,
  input  logic [1:0]        idx,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [16:0] row;
  logic [16:0] col;

  // 17-bit coordinates so a window near 16'hFFFF lands out of range, not at 0
  always_comb begin
    row = {1'b0, win_row};
    col = {1'b0, win_col};
    case (shift_dir)
      DIR_RIGHT: begin
        row = row + 17'd1 + {15'd0, idx};
        col = col + 17'd3;
      end
      DIR_LEFT: begin
        row = row + 17'd1 + {15'd0, idx};
        col = col + 17'd1;
      end
      default: begin
        row = row + 17'd3;
        col = col + 17'd1 + {15'd0, idx};
      end
    endcase
  end

  // Only the low ADDR_W bits of the product are needed, so the multiply is kept narrow
  assign addr     = ADDR_W'(ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col));
  assign in_range = (row < 17'(IMG_H)) && (col < 17'(IMG_W));

endmodule

// File: rtl/nms_result_writer.sv
// Serializes 3-pixel NMS result groups into single-pixel memory writes over a
// req/grant handshake, with frame completion signalling and a write count.
module nms_result_writer
  import canny_pkg::*;
#(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  pixel_t            non_max [0:2],
  input  logic [1:0]        shift_dir,
  input  logic [15:0]       win_row,
  input  logic [15:0]       win_col,
  input  logic              frame_end,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_grant,
  output logic              frame_done,
  output logic [19:0]       pix_count
);

  wr_state_t   state, state_next;
  logic [1:0]  idx;
  logic        pend_end;
  pixel_t      grp_px [0:2];
  logic [1:0]  grp_dir;
  logic [15:0] grp_row;
  logic [15:0] grp_col;

  pixel_t            slot_px;
  logic [ADDR_W-1:0] slot_addr;
  logic              slot_in_range;
  logic              slot_skip;
  logic              advance;
  logic              last_slot;
  logic              accept;

  nms_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .win_row  (grp_row),
    .win_col  (grp_col),
    .shift_dir(grp_dir),
    .idx      (idx),
    .addr     (slot_addr),
    .in_range (slot_in_range)
  );

  always_comb begin
    case (idx)
      2'd0:    slot_px = grp_px[0];
      2'd1:    slot_px = grp_px[1];
      default: slot_px = grp_px[2];
    endcase
  end

  assign accept     = (state == IDLE) && in_valid;
  assign slot_skip  = !slot_in_range || ((SKIP_ZERO != 0) && (slot_px == 8'd0));
  assign mem_req    = (state == WRITE) && !slot_skip;
  assign advance    = (state == WRITE) && (slot_skip || mem_grant);
  assign last_slot  = advance && (idx == IDX_LAST);
  assign in_ready   = (state == IDLE);
  assign frame_done = (state == FLUSH);
  // Address/data read as zero whenever no write is being requested
  assign mem_addr   = mem_req ? slot_addr : '0;
  assign mem_wdata  = mem_req ? slot_px : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid)       state_next = WRITE;
        else if (frame_end) state_next = FLUSH;
      end
      WRITE: begin
        if (last_slot) state_next = (pend_end || frame_end) ? FLUSH : IDLE;
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 2'd0;
      pend_end  <= 1'b0;
      pix_count <= 20'd0;
    end else begin
      if (accept)       idx <= 2'd0;
      else if (advance) idx <= idx + 2'd1;

      if (last_slot)
        pend_end <= 1'b0;
      else if (frame_end && (accept || (state == WRITE)))
        pend_end <= 1'b1;

      if (state == FLUSH)         pix_count <= 20'd0;
      else if (mem_req && mem_grant) pix_count <= pix_count + 20'd1;
    end
  end

  // Group payload is data only; it is qualified by state and needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      grp_px[0] <= non_max[0];
      grp_px[1] <= non_max[1];
      grp_px[2] <= non_max[2];
      grp_dir   <= shift_dir;
      grp_row   <= win_row;
      grp_col   <= win_col;
    end
  end

endmodule

// File: tb/tb_nms_result_writer.sv
// Directed bench for nms_result_writer: table of single groups with grant high,
// plus hand sequences for backpressure, frame_end and mid-write reset.
module tb_nms_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  non_max [0:2];
  logic [1:0]  shift_dir;
  logic [15:0] win_row;
  logic [15:0] win_col;
  logic        frame_end;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_grant;
  logic        frame_done;
  logic [19:0] pix_count;

  int tests = 0;
  int fails = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  nms_result_writer #(
    .IMG_W(64), .IMG_H(64), .ADDR_W(12), .SKIP_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .non_max(non_max), .shift_dir(shift_dir), .win_row(win_row), .win_col(win_col),
    .frame_end(frame_end), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_grant(mem_grant), .frame_done(frame_done),
    .pix_count(pix_count)
  );

  typedef struct {
    logic [1:0]  dir;
    logic [15:0] r;
    logic [15:0] c;
    logic [7:0]  p0, p1, p2;
    int          nw;
    logic [11:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] dir, input logic [15:0] r, input logic [15:0] c,
                         input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    in_valid   = 1'b1;
    shift_dir  = dir;
    win_row    = r;
    win_col    = c;
    non_max[0] = p0;
    non_max[1] = p1;
    non_max[2] = p2;
  endtask

  task automatic run_group(input vec_t v, input int n);
    logic [11:0] ea [3];
    logic [7:0]  ed [3];
    int cyc;
    int nw;
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
    ed[0] = v.d0; ed[1] = v.d1; ed[2] = v.d2;
    check($sformatf("v%0d ready_before", n), in_ready, 1);
    present(v.dir, v.r, v.c, v.p0, v.p1, v.p2);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    nw  = 0;
    while (!in_ready && cyc < 10) begin
      if (mem_req) begin
        if (nw < 3) begin
          check($sformatf("v%0d addr%0d", n, nw), mem_addr, ea[nw]);
          check($sformatf("v%0d data%0d", n, nw), mem_wdata, ed[nw]);
        end
        nw++;
      end
      cyc++;
      tick();
    end
    exp_count += v.nw;
    check($sformatf("v%0d writes", n), nw, v.nw);
    check($sformatf("v%0d cycles", n), cyc, 3);
    check($sformatf("v%0d pix_count", n), pix_count, exp_count);
  endtask

  initial begin
    int pulses;
    int cyc;

    //            dir    r        c    p0  p1  p2   nw  a0    a1    a2    d0  d1  d2
    vecs[0] = '{2'b01, 16'd0,     16'd0,  10, 20, 30,  3, 67,   131,  195,  10, 20, 30};
    vecs[1] = '{2'b11, 16'd2,     16'd5,  0,  7,  0,   1, 327,  0,    0,    7,  0,  0};
    vecs[2] = '{2'b10, 16'd0,     16'd62, 1,  2,  3,   3, 127,  191,  255,  1,  2,  3};
    vecs[3] = '{2'b01, 16'd0,     16'd62, 1,  2,  3,   0, 0,    0,    0,    0,  0,  0};
    vecs[4] = '{2'b00, 16'd60,    16'd0,  5,  6,  7,   3, 4033, 4034, 4035, 5,  6,  7};
    vecs[5] = '{2'b11, 16'd61,    16'd0,  5,  6,  7,   0, 0,    0,    0,    0,  0,  0};
    vecs[6] = '{2'b10, 16'd10,    16'd3,  9,  0,  255, 2, 708,  836,  0,    9,  255, 0};
    vecs[7] = '{2'b01, 16'hFFFF,  16'd0,  1,  2,  3,   0, 0,    0,    0,    0,  0,  0};

    rst = 1'b1;
    in_valid = 1'b0;
    frame_end = 1'b0;
    mem_grant = 1'b1;
    present(2'b01, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0);
    in_valid = 1'b0;
    tick();
    tick();
    check("rst in_ready", in_ready, 1);
    check("rst mem_req", mem_req, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst frame_done", frame_done, 0);
    check("rst pix_count", pix_count, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_group(vecs[i], i);

    // frame_end alone in IDLE flushes next cycle
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("idle_fe frame_done", frame_done, 1);
    check("idle_fe pix_count", pix_count, exp_count);
    tick();
    check("idle_fe done_clear", frame_done, 0);
    check("idle_fe count_clear", pix_count, 0);
    exp_count = 0;

    // Backpressure: grant low for 5 cycles on slot 0, in_valid ignored meanwhile
    mem_grant = 1'b0;
    present(2'b01, 16'd0, 16'd0, 8'd10, 8'd20, 8'd30);
    tick();
    present(2'b10, 16'd5, 16'd5, 8'd99, 8'd98, 8'd97);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp req%0d", i), mem_req, 1);
      check($sformatf("bp addr%0d", i), mem_addr, 67);
      check($sformatf("bp data%0d", i), mem_wdata, 10);
      check($sformatf("bp ready%0d", i), in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    mem_grant = 1'b1;
    check("bp addr0_granted", mem_addr, 67);
    tick();
    check("bp addr1", mem_addr, 131);
    check("bp data1", mem_wdata, 20);
    tick();
    check("bp addr2", mem_addr, 195);
    check("bp data2", mem_wdata, 30);
    tick();
    check("bp ready_after", in_ready, 1);
    check("bp pix_count", pix_count, 3);
    exp_count = 3;

    // Flush to start a clean frame
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    check("bp flush count", pix_count, 0);

    // frame_end coincident with accept
    present(2'b01, 16'd0, 16'd0, 8'd10, 8'd20, 8'd30);
    frame_end = 1'b1;
    tick();
    in_valid = 1'b0;
    frame_end = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fe write%0d", i), mem_req, 1);
      if (frame_done) pulses++;
      tick();
    end
    check("fe done_cycle", frame_done, 1);
    check("fe count_at_done", pix_count, 3);
    check("fe ready_at_done", in_ready, 0);
    pulses += frame_done ? 1 : 0;
    tick();
    check("fe count_after", pix_count, 0);
    check("fe ready_after", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      if (frame_done) pulses++;
      tick();
    end
    check("fe pulses", pulses, 1);
    exp_count = 0;

    // Reset mid-WRITE after first grant
    present(2'b01, 16'd0, 16'd0, 8'd10, 8'd20, 8'd30);
    tick();
    in_valid = 1'b0;
    tick();
    check("rw count_before", pix_count, 1);
    check("rw req_before", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    check("rw req_async", mem_req, 0);
    check("rw count_async", pix_count, 0);
    check("rw ready_async", in_ready, 1);
    tick();
    rst = 1'b0;
    cyc = 0;
    while (mem_req && cyc < 5) begin
      cyc++;
      tick();
    end
    check("rw no_stale_req", cyc, 0);
    exp_count = 0;
    run_group(vecs[0], 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
